// File: rtl/sw_alloc_rr.sv
// Round-robin switch allocator: per-output RR arbitration with packet locking,
// producing a registered conflict-free allocation matrix for the crossbar control.
module sw_alloc_rr #(
  parameter int NUM_PORT     = 5,
  parameter int LOG_NUM_PORT = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORT*NUM_PORT-1:0]   reqVector,
  input  logic [NUM_PORT-1:0]            tailVector,
  input  logic [NUM_PORT-1:0]            outAvail,
  output logic [NUM_PORT*NUM_PORT-1:0]   allocVector,
  output logic [NUM_PORT-1:0]            grantVector,
  output logic [NUM_PORT-1:0]            lockVector
);

  localparam int N  = NUM_PORT;
  localparam int LW = LOG_NUM_PORT;

  typedef logic [LW-1:0] idx_t;
  typedef logic [N-1:0]  vec_t;

  function automatic vec_t lowest_bit(input vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

  // Returns {found, index} of the first set bit of cand, scanning from start with wrap.
  function automatic logic [LW:0] rr_pick(input vec_t cand, input idx_t start);
    logic found;
    idx_t idx;
    int   j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == j) && cand[i]) begin
          found = 1'b1;
          idx   = idx_t'(i);
        end
      end
    end
    return {found, idx};
  endfunction

  function automatic idx_t next_ptr(input idx_t w);
    return (w == idx_t'(N-1)) ? '0 : w + idx_t'(1);
  endfunction

  logic [N-1:0][LW-1:0] ptr;
  logic [N-1:0][LW-1:0] owner;
  logic [N-1:0]         lock;

  vec_t [N-1:0]         req_san;
  logic [N-1:0]         win_vld;
  logic [N-1:0][LW-1:0] win_idx;
  logic [N*N-1:0]       alloc_nxt;
  vec_t                 grant_nxt;

  logic [N*N-1:0]       alloc_p1;
  vec_t                 grant_p1;

  // Stage 0: sanitise requests, arbitrate each output column
  always_comb begin
    req_san = '0;
    for (int i = 0; i < N; i++)
      req_san[i] = lowest_bit(reqVector[i*N +: N]);
  end

  always_comb begin
    vec_t cand;
    cand      = '0;
    win_vld   = '0;
    win_idx   = '0;
    alloc_nxt = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++)
        cand[i] = req_san[i][o] & outAvail[o];
      if (lock[o]) begin
        win_vld[o] = cand[owner[o]];
        win_idx[o] = owner[o];
      end else begin
        {win_vld[o], win_idx[o]} = rr_pick(cand, ptr[o]);
      end
      for (int i = 0; i < N; i++)
        if (win_vld[o] && (win_idx[o] == idx_t'(i)))
          alloc_nxt[i*N + o] = 1'b1;
    end
  end

  always_comb begin
    grant_nxt = '0;
    for (int i = 0; i < N; i++)
      grant_nxt[i] = |alloc_nxt[i*N +: N];
  end

  // Stage 1: registered matrix plus per-output lock/owner/pointer state
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_p1 <= '0;
      grant_p1 <= '0;
      lock     <= '0;
      owner    <= '0;
      ptr      <= '0;
    end else begin
      alloc_p1 <= alloc_nxt;
      grant_p1 <= grant_nxt;
      for (int o = 0; o < N; o++) begin
        if (win_vld[o]) begin
          if (tailVector[win_idx[o]]) begin
            lock[o] <= 1'b0;
            ptr[o]  <= next_ptr(win_idx[o]);
          end else begin
            lock[o]  <= 1'b1;
            owner[o] <= win_idx[o];
          end
        end
      end
    end
  end

  assign allocVector = alloc_p1;
  assign grantVector = grant_p1;
  assign lockVector  = lock;

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Bench for sw_alloc_rr: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural allocator model.
module tb_sw_alloc_rr;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*N-1:0] req_vec;
  logic [N-1:0]   tail_vec;
  logic [N-1:0]   avail_vec;
  logic [N*N-1:0] alloc;
  logic [N-1:0]   grant;
  logic [N-1:0]   lock;

  int tests = 0;
  int fails = 0;

  sw_alloc_rr #(.NUM_PORT(5), .LOG_NUM_PORT(3)) dut (
    .clk        (clk),
    .reset      (rst),
    .reqVector  (req_vec),
    .tailVector (tail_vec),
    .outAvail   (avail_vec),
    .allocVector(alloc),
    .grantVector(grant),
    .lockVector (lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each output remembers a next-priority input and an optional owner.
  int             m_ptr   [N];
  int             m_owner [N];
  bit             m_lock  [N];
  logic [N*N-1:0] exp_alloc;
  logic [N-1:0]   exp_grant;
  logic [N-1:0]   exp_lock;
  bit             model_ready = 0;

  initial begin
    int want [N];
    int winner;
    int cand_i;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int o = 0; o < N; o++) begin
          m_ptr[o] = 0; m_owner[o] = 0; m_lock[o] = 0;
        end
        exp_alloc = '0; exp_grant = '0; exp_lock = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          want[i] = -1;
          for (int o = N-1; o >= 0; o--)
            if (req_vec[i*N + o]) want[i] = o;
        end
        exp_alloc = '0; exp_grant = '0; exp_lock = '0;
        for (int o = 0; o < N; o++) begin
          winner = -1;
          if (avail_vec[o]) begin
            if (m_lock[o]) begin
              if (want[m_owner[o]] == o) winner = m_owner[o];
            end else begin
              for (int k = 0; k < N; k++) begin
                cand_i = (m_ptr[o] + k) % N;
                if (winner < 0 && want[cand_i] == o) winner = cand_i;
              end
            end
          end
          if (winner >= 0) begin
            exp_alloc = exp_alloc | ((N*N)'(1) << (winner*N + o));
            exp_grant[winner] = 1'b1;
            if (tail_vec[winner]) begin
              m_lock[o] = 0;
              m_ptr[o]  = (winner + 1) % N;
            end else begin
              m_lock[o]  = 1;
              m_owner[o] = winner;
            end
          end
          exp_lock[o] = m_lock[o];
        end
      end
      model_ready = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        chk("alloc_vs_model", 32'(alloc), 32'(exp_alloc));
        chk("grant_vs_model", 32'(grant), 32'(exp_grant));
        chk("lock_vs_model",  32'(lock),  32'(exp_lock));
      end
    end
  end

  task automatic step(input logic [N*N-1:0] r, input logic [N-1:0] t,
                      input logic [N-1:0] a, input logic rs);
    @(negedge clk);
    req_vec = r; tail_vec = t; avail_vec = a; rst = rs;
    @(posedge clk);
    #1;
  endtask

  localparam logic [N*N-1:0] PERM = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  localparam logic [N*N-1:0] RR3  = (25'd8 << 0) | (25'd8 << 10) | (25'd8 << 20);
  localparam logic [N*N-1:0] PKT  = (25'd1 << 5) | (25'd1 << 15);
  localparam logic [N*N-1:0] IN3  = (25'd1 << 15);
  localparam logic [N*N-1:0] MH   = (25'b01010 << 10);

  initial begin
    logic [N*N-1:0] r;
    logic [N-1:0]   t, a;
    logic [N-1:0]   rr_exp [4];
    rst = 1'b1; req_vec = '0; tail_vec = '0; avail_vec = '0;

    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b1);
    chk("reset_alloc", 32'(alloc), 32'h0);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_lock",  32'(lock),  32'h0);

    step(PERM, 5'h1f, 5'h1f, 1'b0);
    chk("perm_alloc", 32'(alloc), 32'(PERM));
    chk("perm_grant", 32'(grant), 32'h1f);

    step('0, '0, 5'h1f, 1'b1);
    rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00100; rr_exp[2] = 5'b10000; rr_exp[3] = 5'b00001;
    for (int c = 0; c < 4; c++) begin
      step(RR3, 5'h1f, 5'h1f, 1'b0);
      chk("rr_grant", 32'(grant), 32'(rr_exp[c]));
      chk("rr_model_grant", 32'(exp_grant), 32'(rr_exp[c]));
    end

    step('0, '0, 5'h1f, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(PKT, 5'b01000, 5'h1f, 1'b0);
      chk("pkt_grant", 32'(grant), 32'b00010);
      chk("pkt_lock",  32'(lock),  32'b00001);
    end
    step(PKT, 5'b01010, 5'h1f, 1'b0);
    chk("pkt_tail_grant", 32'(grant), 32'b00010);
    chk("pkt_tail_lock",  32'(lock),  32'b00000);
    step(PKT, 5'b01010, 5'h1f, 1'b0);
    chk("pkt_next_grant", 32'(grant), 32'b01000);
    chk("pkt_next_model", 32'(exp_grant), 32'b01000);

    step('0, '0, 5'h1f, 1'b1);
    step(PKT, 5'b01000, 5'h1f, 1'b0);
    chk("bp_first_grant", 32'(grant), 32'b00010);
    for (int c = 0; c < 2; c++) begin
      step(PKT, 5'b01000, 5'b11110, 1'b0);
      chk("bp_stall_grant", 32'(grant), 32'b00000);
      chk("bp_stall_lock",  32'(lock),  32'b00001);
    end
    step(PKT, 5'b01000, 5'h1f, 1'b0);
    chk("bp_resume_grant", 32'(grant), 32'b00010);
    step(PKT, 5'b01010, 5'h1f, 1'b0);
    chk("bp_tail_lock", 32'(lock), 32'b00000);
    step(PKT, 5'b01010, 5'h1f, 1'b0);
    chk("bp_in3_grant", 32'(grant), 32'b01000);

    step('0, '0, 5'h1f, 1'b1);
    step(PKT, 5'b01000, 5'h1f, 1'b0);
    chk("rstmid_locked", 32'(lock), 32'b00001);
    step(PKT, 5'b01000, 5'h1f, 1'b1);
    chk("rstmid_lock",  32'(lock),  32'b00000);
    chk("rstmid_grant", 32'(grant), 32'b00000);
    step(IN3, 5'b01000, 5'h1f, 1'b0);
    chk("rstmid_in3_grant", 32'(grant), 32'b01000);
    chk("rstmid_in3_alloc", 32'(alloc), 32'(IN3));

    step(MH, 5'h1f, 5'h1f, 1'b0);
    chk("multihot_alloc", 32'(alloc), 32'(25'd1 << 11));
    chk("multihot_grant", 32'(grant), 32'b00100);

    for (int c = 0; c < 3000; c++) begin
      r = '0;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: r[i*N +: N] = '0;
          1, 2: r[i*N +: N] = 5'(1) << $urandom_range(0, N-1);
          default: r[i*N +: N] = 5'($urandom);
        endcase
      end
      for (int i = 0; i < N; i++) begin
        t[i] = ($urandom_range(0, 9) < 6);
        a[i] = ($urandom_range(0, 9) < 8);
      end
      step(r, t, a, ($urandom_range(0, 99) == 0));
    end

    step('0, '0, '0, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
